// File: rtl/hc02_test_seq.sv
// rtl/hc02_test_seq.sv - built-in sequencer exercising four external NOR gates
// Eight vectors per run; each vector is applied, settled, then checked against the synchronized outputs.
module hc02_test_seq #(
   parameter int SETTLE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic [3:0] gate_a,
   output logic [3:0] gate_b,
   input  logic [3:0] gate_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [3:0] err_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_APPLY = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   logic [2:0] state_q, state_d;
   logic [2:0] v_q, v_d;
   logic [3:0] wait_q, wait_d;
   logic [3:0] ga_q, ga_d;
   logic [3:0] gb_q, gb_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [3:0] mask_q, mask_d;
   logic [3:0] err_q, err_d;
   logic [3:0] sync1_q, sync2_q;
   logic [3:0] mism;

   // Vectors 0..3 sweep all NOR input pairs on every gate; 4..7 isolate one gate each.
   function automatic logic [3:0] vec_a(input logic [2:0] v);
      if (!v[2]) return {4{v[1]}};
      return ~(4'b0001 << v[1:0]);
   endfunction

   function automatic logic [3:0] vec_b(input logic [2:0] v);
      if (!v[2]) return {4{v[0]}};
      return 4'b0000;
   endfunction

   function automatic logic [3:0] exp_y(input logic [2:0] v);
      if (!v[2]) return (v[1:0] == 2'd0) ? 4'b1111 : 4'b0000;
      return 4'b0001 << v[1:0];
   endfunction

   assign mism = sync2_q ^ exp_y(v_q);

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      wait_d  = wait_q;
      ga_d    = ga_q;
      gb_d    = gb_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      mask_d  = mask_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_APPLY;
               v_d     = 3'd0;
               ga_d    = vec_a(3'd0);
               gb_d    = vec_b(3'd0);
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               mask_d  = 4'b0000;
               err_d   = 4'd0;
            end
         end
         S_APPLY: begin
            state_d = S_WAIT;
            wait_d  = SETTLE_CNT;
         end
         S_WAIT: begin
            wait_d = wait_q - 4'd1;
            if (wait_q == 4'd1) state_d = S_CHECK;
         end
         S_CHECK: begin
            mask_d = mask_q | mism;
            if ((mism != 4'b0000) && (err_q != 4'd15)) err_d = err_q + 4'd1;
            if (v_q == 3'd7) begin
               state_d = S_FIN;
            end else begin
               state_d = S_APPLY;
               v_d     = v_q + 3'd1;
               ga_d    = vec_a(v_q + 3'd1);
               gb_d    = vec_b(v_q + 3'd1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            v_d     = 3'd0;
            ga_d    = 4'b0000;
            gb_d    = 4'b0000;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mask_q == 4'b0000);
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything above; result flags stay frozen for inspection.
      if (abort && busy_q) begin
         state_d = S_IDLE;
         v_d     = 3'd0;
         wait_d  = 4'd0;
         ga_d    = 4'b0000;
         gb_d    = 4'b0000;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         mask_d  = mask_q;
         err_d   = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         v_q     <= 3'd0;
         wait_q  <= 4'd0;
         ga_q    <= 4'b0000;
         gb_q    <= 4'b0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= 4'b0000;
         err_q   <= 4'd0;
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         wait_q  <= wait_d;
         ga_q    <= ga_d;
         gb_q    <= gb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         sync1_q <= gate_y;
         sync2_q <= sync1_q;
      end
   end

   assign gate_a    = ga_q;
   assign gate_b    = gb_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = mask_q;
   assign err_count = err_q;

endmodule

// File: doc/hc02_test_seq.md
HC02_TEST_SEQ -- requirements
Module: hc02_test_seq

Interface
REQ-001 The block SHALL have parameter SETTLE, default 3, legal range 2..15: wait cycles between applying a vector and checking the DUT outputs.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: begin a test run; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancel the run in progress.
REQ-006 The block SHALL have port gate_a, output, 4 bits: A inputs of the four DUT NOR gates, registered.
REQ-007 The block SHALL have port gate_b, output, 4 bits: B inputs of the four DUT NOR gates, registered.
REQ-008 The block SHALL have port gate_y, input, 4 bits: DUT gate outputs, asynchronous to clk.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a completed run.
REQ-011 The block SHALL have port pass, output, 1 bit: run result, held until the next start or abort.
REQ-012 The block SHALL have port fail_mask, output, 4 bits: sticky per-gate failure flags.
REQ-013 The block SHALL have port err_count, output, 4 bits: number of mismatching vectors, saturating at 15.

Function
REQ-014 The block SHALL pass gate_y through a 2-flop synchronizer before any comparison.
REQ-015 The block SHALL implement the state machine IDLE -> APPLY -> WAIT -> CHECK -> (APPLY | FIN) -> IDLE.
REQ-016 A start sampled high in IDLE SHALL, on that edge, select vector index v=0, set busy=1, clear fail_mask, err_count and pass, and drive vector 0 onto gate_a/gate_b.
REQ-017 APPLY SHALL last 1 cycle, WAIT exactly SETTLE cycles (counted by a down-counter), and CHECK 1 cycle, so each vector occupies SETTLE+2 cycles.
REQ-018 For v=0..3, every gate SHALL receive a=v[1] and b=v[0], and the expected output SHALL be 4'b1111 when v=0 and 4'b0000 otherwise.
REQ-019 For v=4..7, with k=v-4, gate k SHALL receive a=0, b=0 and all other gates a=1, b=0; the expected output SHALL be one-hot bit k.
REQ-020 In CHECK, mismatching bits of (synchronized y XOR expected) SHALL be ORed into fail_mask, and err_count SHALL increment by 1 if any bit mismatches, saturating at 15.
REQ-021 After the CHECK for v=7, the block SHALL enter FIN for 1 cycle with done=1 and pass=(fail_mask==0 including that CHECK's result), then return to IDLE with busy=0 and gate_a=gate_b=0.
REQ-022 done SHALL rise exactly 8*(SETTLE+2)+1 cycles after the edge that sampled start (41 cycles for SETTLE=3).
REQ-023 start asserted while busy SHALL be ignored; start held high SHALL relaunch only once back in IDLE.
REQ-024 abort sampled high while busy SHALL return the block to IDLE on that edge with busy=0, gate_a=gate_b=0, pass=0, no done pulse, and fail_mask/err_count frozen.
REQ-025 abort SHALL take priority over start and over the FIN transition when both occur on the same edge.
REQ-026 The block SHALL be fully synchronous, with no combinational path from gate_y to any output.

Reset
REQ-027 When rst is high, the next edge SHALL force state=IDLE, v=0, gate_a=0, gate_b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, synchronizer flops=0, and wait counter=0.
REQ-028 rst SHALL override start and abort, including mid-run, and the block SHALL accept start on the first edge after rst deasserts.

Verification
REQ-029 Good DUT model (y=~(a|b), 1-cycle delay), SETTLE=3, start pulse -> done at cycle 41, pass=1, fail_mask=0000, err_count=0.
REQ-030 Gate 2 stuck-at-0 -> pass=0, fail_mask=0100, err_count=2 (mismatches at v=0 and v=6).
REQ-031 Bridge forcing y1=y0 -> pass=0, fail_mask=0010, err_count=2 (mismatches at v=4 and v=5).
REQ-032 abort at cycle 10 of a run -> next cycle busy=0, gate_a=gate_b=0, pass=0, and no done pulse ever follows.
REQ-033 start re-pulsed at cycle 5 while busy -> ignored, done still at cycle 41; a new start after done clears err_count and fail_mask to 0 on its accepting edge.
REQ-034 rst asserted at cycle 20 with a faulty DUT -> every output at its reset value on the next cycle, and a new start completes normally.
